// File: rtl/parking_meter_ctrl.sv
// Parking-meter sequencer: remaining-time count, coin adds, presets, 1 Hz countdown, meter state.
// Optional METER_BTN_EDGE_EN: coin buttons add once per rising edge instead of every cycle high.
module parking_meter_ctrl #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned MAX_TIME = 9999
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic [3:0]  BTN_ADD,
    input  logic        SW_PRE10,
    input  logic        SW_PRE205,
    output logic [15:0] Time_Bin16,
    output logic        Tick_1Hz,
    output logic [1:0]  Meter_State,
    output logic        Expired
);

    localparam int unsigned   CW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOW  = 2'b01,
        RUN  = 2'b10
    } state_t;

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic [CW-1:0] cnt_next;
    logic [3:0]    btn_eff;
    logic [15:0]   add_val;
    logic [15:0]   base;
    logic [16:0]   sum;
    logic [15:0]   t_next;
    logic          preset;

`ifdef METER_BTN_EDGE_EN
    logic [3:0] btn_hist;

    // History cleared in reset, so a button held through reset release counts as an edge.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) btn_hist <= '0;
        else         btn_hist <= BTN_ADD;
    end

    assign btn_eff = BTN_ADD & ~btn_hist;
`else
    assign btn_eff = BTN_ADD;
`endif

    function automatic state_t state_of(input logic [15:0] t);
        if (t == 16'd0)       return IDLE;
        else if (t < 16'd200) return LOW;
        else                  return RUN;
    endfunction

    assign preset = SW_PRE205 | SW_PRE10;

    always_comb begin
        add_val = '0;
        if (btn_eff[0])      add_val = 16'd50;
        else if (btn_eff[1]) add_val = 16'd150;
        else if (btn_eff[2]) add_val = 16'd200;
        else if (btn_eff[3]) add_val = 16'd500;
    end

    always_comb begin
        cnt_next = tick_cnt + CW'(1);
        if (preset || tick_cnt == TICK_LAST) cnt_next = '0;
    end

    // Decrement before the add so a tick at the ceiling or at zero still nets correctly.
    always_comb begin
        base = Time_Bin16;
        if (Tick_1Hz && Time_Bin16 != '0) base = Time_Bin16 - 16'd1;
        sum    = {1'b0, base} + {1'b0, add_val};
        t_next = sum[15:0];
        if (SW_PRE205)                 t_next = 16'd205;
        else if (SW_PRE10)             t_next = 16'd10;
        else if (sum > 17'(MAX_TIME))  t_next = 16'(MAX_TIME);
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            tick_cnt   <= '0;
            Tick_1Hz   <= 1'b0;
            Time_Bin16 <= '0;
            state      <= IDLE;
            Expired    <= 1'b1;
        end else begin
            tick_cnt   <= cnt_next;
            Tick_1Hz   <= (cnt_next == TICK_LAST);
            Time_Bin16 <= t_next;
            state      <= state_of(t_next);
            Expired    <= (t_next == '0);
        end
    end

    assign Meter_State = state;

endmodule

// File: doc/parking_meter_ctrl.md
# parking_meter_ctrl

Sequencing controller for the parking-meter datapath. Holds the 16-bit remaining-time count and applies coin adds, preset loads and the once-per-second countdown. Drives the binary time value into the binary-to-BCD display stage and reports meter state (idle/low/run). Owns the 1 Hz tick, so the countdown and display flashing share one time base.

## Interface
Parameters:
- CLK_HZ, 100_000_000, SYS_CLK cycles per countdown tick
- MAX_TIME, 9999, saturation ceiling for the time count

Ports:
- SYS_CLK  input  1  system clock; all state updates on rising edge
- SYS_RST  input  1  reset, synchronous, active-high
- BTN_ADD  input  4  coin buttons; bit0 +50, bit1 +150, bit2 +200, bit3 +500
- SW_PRE10  input  1  level preset; load 10 while high
- SW_PRE205  input  1  level preset; load 205 while high
- Time_Bin16  output  16  remaining seconds, binary, 0..MAX_TIME
- Tick_1Hz  output  1  one-cycle pulse per countdown period
- Meter_State  output  2  00 IDLE, 01 LOW, 10 RUN; 11 never driven
- Expired  output  1  high when Time_Bin16 == 0

## Operation
- Reset: Time_Bin16=0, tick counter=0, Tick_1Hz=0, Meter_State=IDLE, Expired=1. Edge-detect history cleared to 0 when the edge-detect feature is compiled in. Reset overrides every other input in the same cycle. Reset mid-count discards the partial tick period.
- Tick generator: counter runs 0..CLK_HZ-1 and wraps. Tick_1Hz=1 for the single cycle the counter equals CLK_HZ-1. It free-runs in every state, including IDLE.
- Add selection: at most one add per cycle. The lowest set index of the effective button vector wins, so simultaneous presses apply only the lowest-index value. A is that value, or 0 if no button is effective.
- Update priority each cycle:
  1. SYS_RST.
  2. Preset: SW_PRE205 loads 205. Otherwise SW_PRE10 loads 10. Presets also clear the tick counter to 0, and buttons and tick are ignored that cycle. A held preset reloads every cycle.
  3. Normal: base = (Tick_1Hz && T>0) ? T-1 : T. next = min(base + A, MAX_TIME).
- Arithmetic: the sum is computed 17 bits wide, then saturated. T never wraps below 0 or above MAX_TIME.
- FSM: next state is a pure function of the next T.
  - IDLE when T==0.
  - LOW when 1<=T<=199.
  - RUN when T>=200.
  - Legal transitions: any to any through adds and presets. Countdown gives only RUN->LOW at 200->199 and LOW->IDLE at 1->0.
- Expired is registered alongside T and always equals (Time_Bin16==0).

## Timing
- All outputs are registered. Time_Bin16, Meter_State and Expired update together, on the same edge.
- Latency: an effective button or preset seen at edge N is reflected in the outputs after edge N.
- Tick_1Hz asserts in the cycle the counter equals CLK_HZ-1. The decrement lands at the end of that same cycle.
- After reset release, the first tick fires at the CLK_HZ-th edge.
- Tick and add in the same cycle: the decrement applies first, then the add, then saturation.
  - Example: T=9999, tick, +50 gives 9999.
  - Example: T=0, tick, +50 gives 50.

## Configuration
- METER_BTN_EDGE_EN defined:
  - Each BTN_ADD bit passes through a one-cycle history register.
  - Effective button = BTN_ADD & ~history, so a held button adds exactly once per rising edge.
  - A button already high when reset deasserts counts as a rising edge.
- Not defined:
  - BTN_ADD is used directly. Every cycle a bit is high counts as a press.
  - Upstream must supply single-cycle pulses.

## Test plan
- Reset with CLK_HZ=4. Outputs 0 / IDLE / Expired=1. Wait 4 edges: Tick_1Hz pulses once and T stays 0.
- BTN_ADD=0001 for one cycle -> T=50, LOW. After 50 ticks -> T=0, IDLE, Expired=1.
- SW_PRE205=1 and SW_PRE10=1 for one cycle, with BTN_ADD=1000 also asserted -> T=205, RUN, tick counter 0. Release; 6 ticks later -> T=199, LOW.
- T=9800, BTN_ADD=1000 -> T=9999. A further +50 coinciding with a tick -> T=9999.
- BTN_ADD=0110 asserted together for one cycle from T=0 -> T=150 (only bit1 applied).
- With METER_BTN_EDGE_EN: hold bit2 for 10 cycles -> T=200 once. Without it: hold bit2 for 3 cycles from 0, no tick -> T=600.
